hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. Tracks the destination and source registers of the instructions in E, M and W in its own shadow pipeline registers. Drives the ForwardAE/ForwardBE selects of the two execute-stage forwarding muxes. Generates stall and flush controls for load-use hazards, taken branches/jumps, and multi-cycle data-memory accesses.

## Interface
- No parameters; register index width fixed at 5, XLEN-independent.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- Rs1D, Rs2D  in  5 each  decode-stage source indices
- RdD  in  5  decode-stage destination index
- RegWriteD  in  1  decode instruction writes rd
- LoadD  in  1  decode instruction is a load (ResultSrcD selects memory)
- MemAccD  in  1  decode instruction is a load or store
- PCSrcE  in  1  taken branch/jump resolved in E
- MemReadyM  in  1  data memory completes the M-stage access this cycle
- ForwardAE, ForwardBE  out  2 each  00 RF read, 01 ResultW, 10 ALUResultM; 11 never driven
- StallF, StallD, StallE, StallM  out  1 each  hold stage register
- FlushD, FlushE, FlushW  out  1 each  insert bubble into stage register
- MemBusy  out  1  memory-wait FSM in WAIT

## Operation
- Shadow registers: E {Rs1E, Rs2E, RdE, RegWriteE, LoadE, MemAccE}, M {RdM, RegWriteM, MemAccM}, W {RdW, RegWriteW}. They advance exactly as the datapath stage registers do under this block's own stall/flush outputs.
- Forwarding for each of Rs1E/Rs2E:
  - 10 if RegWriteM and RdM!=0 and RdM==RsE.
  - Else 01 if RegWriteW and RdW!=0 and RdW==RsE.
  - Else 00.
  - M has priority over W. x0 is never forwarded.
- Load-use: lwStall = LoadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D). Asserts StallF, StallD, FlushE.
- Branch: PCSrcE asserts FlushD and FlushE. lwStall and PCSrcE are mutually exclusive because E holds one instruction.
- Memory wait: memStall = MemAccM and not MemReadyM. Asserts StallF, StallD, StallE, StallM, FlushW. Forces FlushD, FlushE and lwStall-derived outputs low (pipeline frozen). A branch in E takes effect on the first cycle after release.
- Memory-wait FSM states IDLE, WAIT:
  - IDLE→WAIT when memStall.
  - WAIT→IDLE when MemReadyM.
  - MemBusy=1 in WAIT.
  - rst from any state → IDLE.

## Timing
- Forward and stall/flush outputs are combinational from shadow registers and current inputs (same-cycle). Shadow registers update on the rising clk edge.
- Shadow register update rules:
  - E loads D inputs when !StallE. E clears when FlushE and !StallE.
  - M loads E when !StallM.
  - W loads M when not FlushW, and clears when FlushW.
- Reset: all shadow registers 0, FSM IDLE. All outputs 0, so ForwardAE/BE=00 and no stalls or flushes.
- Reset asserted mid-stall: next cycle all outputs 0, FSM IDLE, pending branch discarded.
- MemReadyM high in the same cycle MemAccM rises: no stall, FSM stays IDLE.

## Configuration
- HAZARD_PERF_EN defined: adds outputs LoadStallCnt, MemStallCnt, FlushCnt (32-bit each, wrap on overflow, reset to 0).
  - LoadStallCnt increments per cycle lwStall is effective.
  - MemStallCnt increments per memStall cycle.
  - FlushCnt increments per cycle PCSrcE flush is effective.
- Undefined: ports and counters absent. All other behaviour identical.

## Structure
- hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), mem_state_t (IDLE, WAIT), REG_ZERO=5'd0.
- Sub-module fwd_sel_unit: combinational priority compare for one source. Instantiated twice, for A and B.

## Test plan
- Prior instr add x5 (now in M), current Rs1E=5 → ForwardAE=10; same with instr in W only → ForwardAE=01; RdM=RdW=5 → 10.
- Rd=x0 with RegWrite, Rs2E=0 → ForwardBE=00 in both M and W positions.
- lw x3 in E, Rs1D=3 → StallF=StallD=FlushE=1 for one cycle; next cycle ForwardAE=01 from W.
- PCSrcE=1 → FlushD=FlushE=1, no stalls; E shadow cleared next cycle.
- Load in M, MemReadyM low 3 cycles → StallF/D/E/M=FlushW=1 and MemBusy=1 for 3 cycles, all 0 after MemReadyM; PCSrcE held during wait flushes only after release.
- rst pulsed during WAIT → outputs all 0 next cycle; with HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the RV32I pipeline hazard controller.
// Forwarding selects, memory-wait FSM states and the x0 index.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel_unit.sv
// Forwarding select for one execute-stage source operand.
// The M-stage result wins over W; x0 is never forwarded.
module fwd_sel_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       regWriteM,
    input  logic       regWriteW,
    output fwd_sel_t   sel
);

    logic hitM;
    logic hitW;

    assign hitM = regWriteM && (rdM != REG_ZERO) && (rdM == rsE);
    assign hitW = regWriteW && (rdW != REG_ZERO) && (rdW == rsE);

    always_comb begin
        sel = FWD_RF;
        if (hitM)
            sel = FWD_MEM;
        else if (hitW)
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use / branch / memory-wait stall+flush.
// Define HAZARD_PERF_EN to add the LoadStallCnt/MemStallCnt/FlushCnt counters.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        RegWriteD,
    input  logic        LoadD,
    input  logic        MemAccD,
    input  logic        PCSrcE,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] LoadStallCnt,
    output logic [31:0] MemStallCnt,
    output logic [31:0] FlushCnt
`endif
);

    logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, LoadE, MemAccE;
    logic       RegWriteM, MemAccM;
    logic       RegWriteW;

    mem_state_t state, stateNext;
    fwd_sel_t   fwdA, fwdB;

    logic lwStall, memStall, lwEff, brEff;

    fwd_sel_unit uFwdA (
        .rsE       (Rs1E),
        .rdM       (RdM),
        .rdW       (RdW),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .sel       (fwdA)
    );

    fwd_sel_unit uFwdB (
        .rsE       (Rs2E),
        .rdM       (RdM),
        .rdW       (RdW),
        .regWriteM (RegWriteM),
        .regWriteW (RegWriteW),
        .sel       (fwdB)
    );

    assign ForwardAE = fwdA;
    assign ForwardBE = fwdB;

    // A memory wait freezes the pipe, masking load-use and branch effects.
    assign memStall = MemAccM && !MemReadyM;
    assign lwStall  = LoadE && (RdE != REG_ZERO)
                    && ((RdE == Rs1D) || (RdE == Rs2D));
    assign lwEff    = lwStall && !memStall;
    assign brEff    = PCSrcE && !memStall;

    assign StallF  = memStall || lwEff;
    assign StallD  = memStall || lwEff;
    assign StallE  = memStall;
    assign StallM  = memStall;
    assign FlushD  = brEff;
    assign FlushE  = brEff || lwEff;
    assign FlushW  = memStall;
    assign MemBusy = (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst || (!StallE && FlushE)) begin
            Rs1E      <= REG_ZERO;
            Rs2E      <= REG_ZERO;
            RdE       <= REG_ZERO;
            RegWriteE <= 1'b0;
            LoadE     <= 1'b0;
            MemAccE   <= 1'b0;
        end else if (!StallE) begin
            Rs1E      <= Rs1D;
            Rs2E      <= Rs2D;
            RdE       <= RdD;
            RegWriteE <= RegWriteD;
            LoadE     <= LoadD;
            MemAccE   <= MemAccD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RdM       <= REG_ZERO;
            RegWriteM <= 1'b0;
            MemAccM   <= 1'b0;
        end else if (!StallM) begin
            RdM       <= RdE;
            RegWriteM <= RegWriteE;
            MemAccM   <= MemAccE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || FlushW) begin
            RdW       <= REG_ZERO;
            RegWriteW <= 1'b0;
        end else begin
            RdW       <= RdM;
            RegWriteW <= RegWriteM;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (memStall) stateNext = WAIT;
            WAIT: if (MemReadyM) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            LoadStallCnt <= 32'd0;
            MemStallCnt  <= 32'd0;
            FlushCnt     <= 32'd0;
        end else begin
            if (lwEff)
                LoadStallCnt <= LoadStallCnt + 32'd1;
            if (memStall)
                MemStallCnt <= MemStallCnt + 32'd1;
            if (brEff)
                FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-output queue.
// Expected word: {FwdA,FwdB,StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,MemBusy}.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, LoadD, MemAccD, PCSrcE, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW, MemBusy;
`ifdef HAZARD_PERF_EN
    logic [31:0] LoadStallCnt, MemStallCnt, FlushCnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] expQ[$];
    string       tagQ[$];

    localparam logic [11:0] NONE   = 12'b00_00_0000_0000;
    localparam logic [11:0] LWST   = 12'b00_00_1100_0100;
    localparam logic [11:0] BRFL   = 12'b00_00_0000_1100;
    localparam logic [11:0] MEM0   = 12'b00_00_1111_0010;
    localparam logic [11:0] MEM1   = 12'b00_00_1111_0011;
    localparam logic [11:0] REL    = 12'b00_00_0000_1101;
    localparam logic [11:0] A_MEM  = 12'b10_00_0000_0000;
    localparam logic [11:0] A_WB   = 12'b01_00_0000_0000;
    localparam logic [11:0] AWB_BM = 12'b01_10_0000_0000;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .RdD          (RdD),
        .RegWriteD    (RegWriteD),
        .LoadD        (LoadD),
        .MemAccD      (MemAccD),
        .PCSrcE       (PCSrcE),
        .MemReadyM    (MemReadyM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .MemBusy      (MemBusy)
`ifdef HAZARD_PERF_EN
        ,
        .LoadStallCnt (LoadStallCnt),
        .MemStallCnt  (MemStallCnt),
        .FlushCnt     (FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(
        input string      tag,
        input logic       r,
        input logic [4:0] s1,
        input logic [4:0] s2,
        input logic [4:0] d,
        input logic       rw,
        input logic       ld,
        input logic       ma,
        input logic       pc,
        input logic       rdy,
        input logic [11:0] exp
    );
        logic [11:0] got;
        logic [11:0] want;
        string       t;
        @(negedge clk);
        rst       = r;
        Rs1D      = s1;
        Rs2D      = s2;
        RdD       = d;
        RegWriteD = rw;
        LoadD     = ld;
        MemAccD   = ma;
        PCSrcE    = pc;
        MemReadyM = rdy;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        #1;
        got = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemBusy};
        want = expQ.pop_front();
        t = tagQ.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", t, got, want);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic chkCnt(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        Rs1D = '0; Rs2D = '0; RdD = '0;
        RegWriteD = 1'b0; LoadD = 1'b0; MemAccD = 1'b0;
        PCSrcE = 1'b0; MemReadyM = 1'b1;

        //    tag        rst s1  s2  rd  rw ld ma pc rdy exp
        step("reset",    1, 0,  0,  0,  0, 0, 0, 0, 1, NONE);

        step("a1",       0, 1,  2,  5,  1, 0, 0, 0, 1, NONE);
        step("a2",       0, 5,  0,  6,  1, 0, 0, 0, 1, NONE);
        step("fwdA_M",   0, 5,  6,  7,  0, 0, 0, 0, 1, A_MEM);
        step("fwdA_W",   0, 0,  0,  0,  0, 0, 0, 0, 1, AWB_BM);
        step("a5",       0, 0,  0,  5,  1, 0, 0, 0, 1, NONE);
        step("a6",       0, 0,  0,  5,  1, 0, 0, 0, 1, NONE);
        step("a7",       0, 5,  0,  0,  0, 0, 0, 0, 1, NONE);
        step("fwdMprio", 0, 0,  0,  0,  0, 0, 0, 0, 1, A_MEM);
        step("a9",       0, 0,  0,  0,  1, 0, 0, 0, 1, NONE);
        step("a10",      0, 0,  0,  0,  0, 0, 0, 0, 1, NONE);
        step("x0_M",     0, 0,  0,  0,  0, 0, 0, 0, 1, NONE);
        step("x0_W",     0, 0,  0,  0,  0, 0, 0, 0, 1, NONE);

        step("lw_issue", 0, 1,  0,  3,  1, 1, 1, 0, 1, NONE);
        step("lw_use",   0, 3,  4,  8,  1, 0, 0, 0, 1, LWST);
        step("lw_bub",   0, 3,  4,  8,  1, 0, 0, 0, 1, NONE);
        step("lw_fwdW",  0, 0,  0,  0,  0, 0, 0, 0, 1, A_WB);

        step("br_flush", 0, 1,  0,  9,  1, 1, 1, 1, 1, BRFL);
        step("br_clrE",  0, 9,  0, 10,  0, 0, 0, 0, 1, NONE);

        step("m1",       0, 0,  0, 11,  1, 1, 1, 0, 1, NONE);
        step("m2",       0, 0,  0,  0,  0, 0, 0, 0, 1, NONE);
        step("mw1",      0, 11, 0, 12,  1, 0, 0, 0, 0, MEM0);
        step("mw2",      0, 11, 0, 12,  1, 0, 0, 1, 0, MEM1);
        step("mw3",      0, 11, 0, 12,  1, 0, 0, 1, 0, MEM1);
        step("mw_rel",   0, 11, 0, 12,  1, 0, 0, 1, 1, REL);
        step("mw_after", 0, 0,  0, 13,  1, 1, 1, 0, 1, NONE);
`ifdef HAZARD_PERF_EN
        chkCnt("cnt_lw",    LoadStallCnt, 32'd1);
        chkCnt("cnt_mem",   MemStallCnt,  32'd3);
        chkCnt("cnt_flush", FlushCnt,     32'd2);
`endif

        step("r1",       0, 0,  0,  0,  0, 0, 0, 0, 1, NONE);
        step("r_w1",     0, 0,  0,  0,  0, 0, 0, 1, 0, MEM0);
        step("r_w2",     0, 0,  0,  0,  0, 0, 0, 1, 0, MEM1);
        step("r_pulse",  1, 0,  0,  0,  0, 0, 0, 1, 0, MEM1);
        step("r_clear",  0, 0,  0,  0,  0, 0, 0, 0, 0, NONE);
        step("r_idle",   0, 0,  0,  0,  0, 0, 0, 0, 1, NONE);
`ifdef HAZARD_PERF_EN
        chkCnt("cnt_rst_lw",    LoadStallCnt, 32'd0);
        chkCnt("cnt_rst_mem",   MemStallCnt,  32'd0);
        chkCnt("cnt_rst_flush", FlushCnt,     32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
